// File: rtl/bird_move.sv
// ----------------------------------------------------------------------------
// bird_move
// Per-frame motion controller for the bird sprite. The bird waits at the sling
// while the player trims launch power. A fire key launches it on a 45 degree
// trajectory under gravity. It freezes on a hit or on landing, then re-arms.
// All motion updates happen on the startOfFrame pulse.
//
// Ports:
//   clk           in   system clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse per video frame (update strobe)
//   fireKey       in   keypad level, rising edge launches from the sling
//   powerUpKey    in   keypad level, rising edge raises launch power
//   powerDownKey  in   keypad level, rising edge lowers launch power
//   collision     in   bird hit something, may pulse on any cycle
//   topLeftX      out  signed 11-bit sprite X position, pixels
//   topLeftY      out  signed 11-bit sprite Y position, pixels (may be < 0)
//   birdVisible   out  high while flying or frozen after a hit
//   power         out  current launch power (fixed-point units per frame)
//
// Build option:
//   BIRD_BOUNCE_EN  when defined, the floor reflects vy at half magnitude
//                   instead of ending the flight, until vy is small.
//
// States:
//   state  | meaning
//   IDLE   | at the sling, power keys active, waiting for fire
//   FLYING | ballistic motion, one step per frame
//   HIT    | position frozen for HIT_HOLD_FRAMES frames
//
// Positions and velocities are 17-bit signed, scaled by 64 (6 fraction bits).
// ----------------------------------------------------------------------------
module bird_move #(
    parameter int INITIAL_X       = 64,
    parameter int INITIAL_Y       = 352,
    parameter int FLOOR_Y         = 448,
    parameter int SCREEN_RIGHT    = 639,
    parameter int GRAVITY         = 4,
    parameter int POWER_MIN       = 64,
    parameter int POWER_MAX       = 512,
    parameter int POWER_STEP      = 16,
    parameter int HIT_HOLD_FRAMES = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               fireKey,
    input  logic               powerUpKey,
    input  logic               powerDownKey,
    input  logic               collision,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               birdVisible,
    output logic [9:0]         power
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLYING = 2'd1,
        HIT    = 2'd2
    } state_t;

    localparam logic signed [16:0] SLING_X_FX = 17'(INITIAL_X * 64);
    localparam logic signed [16:0] SLING_Y_FX = 17'(INITIAL_Y * 64);
    localparam logic signed [16:0] FLOOR_FX   = 17'(FLOOR_Y * 64);
    localparam logic signed [16:0] RIGHT_FX   = 17'(SCREEN_RIGHT * 64);
    localparam logic signed [16:0] GRAV_FX    = 17'(GRAVITY);

    localparam int              HOLD_W    = $clog2(HIT_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HIT_HOLD_FRAMES - 1);

    state_t              state;
    logic signed [16:0]  x_pos;
    logic signed [16:0]  y_pos;
    logic signed [16:0]  vx;
    logic signed [16:0]  vy;
    logic [HOLD_W-1:0]   hold_cnt;

    logic fire_d, up_d, down_d;
    logic fire_flag, up_flag, down_flag, col_flag;

    // ------------------------------------------------------------------
    // Input edge detection; an event in the update cycle itself is folded
    // in directly so it is not lost when the flags are cleared.
    // ------------------------------------------------------------------
    logic fire_edge, up_edge, down_edge;
    logic fire_evt, up_evt, down_evt, col_evt;

    assign fire_edge = fireKey & ~fire_d;
    assign up_edge   = powerUpKey & ~up_d;
    assign down_edge = powerDownKey & ~down_d;

    assign fire_evt = fire_flag | fire_edge;
    assign up_evt   = up_flag   | up_edge;
    assign down_evt = down_flag | down_edge;
    assign col_evt  = col_flag  | collision;

    // ------------------------------------------------------------------
    // Motion arithmetic
    // ------------------------------------------------------------------
    logic signed [16:0] step_x, step_y, step_vy;
    logic signed [16:0] launch_v, launch_x, launch_y, launch_vy;

    assign step_x  = x_pos + vx;
    assign step_y  = y_pos + vy;
    assign step_vy = vy + GRAV_FX;

    // Launch frame applies the first motion step as well, so the bird is
    // already one step out of the sling when it first becomes visible.
    assign launch_v  = signed'({7'd0, power});
    assign launch_x  = SLING_X_FX + launch_v;
    assign launch_y  = SLING_Y_FX - launch_v;
    assign launch_vy = GRAV_FX - launch_v;

`ifdef BIRD_BOUNCE_EN
    localparam logic signed [16:0] BOUNCE_STOP = 17'(4 * GRAVITY);
    logic signed [16:0] half_vy;
    logic signed [16:0] bounce_vy;
    logic               bounce_stop;

    // vy is downward (positive) whenever the floor is reached, so the
    // magnitude of the reflected velocity is simply half_vy.
    assign half_vy     = vy >>> 1;
    assign bounce_vy   = -half_vy;
    assign bounce_stop = (half_vy < BOUNCE_STOP);
`endif

    // ------------------------------------------------------------------
    // Power adjust; opposing edges in one frame cancel.
    // ------------------------------------------------------------------
    logic [10:0] power_inc;
    logic [9:0]  power_nxt;

    assign power_inc = {1'b0, power} + 11'(POWER_STEP);

    always_comb begin
        power_nxt = power;
        if (up_evt && !down_evt) begin
            if (power_inc > 11'(POWER_MAX))
                power_nxt = 10'(POWER_MAX);
            else
                power_nxt = power_inc[9:0];
        end else if (down_evt && !up_evt) begin
            if (power < 10'(POWER_MIN + POWER_STEP))
                power_nxt = 10'(POWER_MIN);
            else
                power_nxt = power - 10'(POWER_STEP);
        end
    end

    // ------------------------------------------------------------------
    // Main FSM, input capture and position registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            x_pos       <= SLING_X_FX;
            y_pos       <= SLING_Y_FX;
            vx          <= '0;
            vy          <= '0;
            hold_cnt    <= '0;
            birdVisible <= 1'b0;
            power       <= 10'(POWER_MIN);
            fire_d      <= 1'b0;
            up_d        <= 1'b0;
            down_d      <= 1'b0;
            fire_flag   <= 1'b0;
            up_flag     <= 1'b0;
            down_flag   <= 1'b0;
            col_flag    <= 1'b0;
        end else begin
            fire_d <= fireKey;
            up_d   <= powerUpKey;
            down_d <= powerDownKey;

            if (!startOfFrame) begin
                if (fire_edge) fire_flag <= 1'b1;
                if (up_edge)   up_flag   <= 1'b1;
                if (down_edge) down_flag <= 1'b1;
                if (collision) col_flag  <= 1'b1;
            end else begin
                fire_flag <= 1'b0;
                up_flag   <= 1'b0;
                down_flag <= 1'b0;
                col_flag  <= 1'b0;

                case (state)
                    IDLE: begin
                        power <= power_nxt;
                        if (fire_evt) begin
                            x_pos       <= launch_x;
                            y_pos       <= launch_y;
                            vx          <= launch_v;
                            vy          <= launch_vy;
                            state       <= FLYING;
                            birdVisible <= 1'b1;
                        end
                    end

                    FLYING: begin
                        if (col_evt) begin
                            state    <= HIT;
                            hold_cnt <= HOLD_LOAD;
                        end else if (step_y >= FLOOR_FX) begin
                            x_pos <= step_x;
                            y_pos <= FLOOR_FX;
`ifdef BIRD_BOUNCE_EN
                            vy <= bounce_vy;
                            if (bounce_stop) begin
                                state    <= HIT;
                                hold_cnt <= HOLD_LOAD;
                            end else if (step_x > RIGHT_FX) begin
                                state       <= IDLE;
                                birdVisible <= 1'b0;
                                x_pos       <= SLING_X_FX;
                                y_pos       <= SLING_Y_FX;
                                vx          <= '0;
                                vy          <= '0;
                            end
`else
                            state    <= HIT;
                            hold_cnt <= HOLD_LOAD;
`endif
                        end else if (step_x > RIGHT_FX) begin
                            state       <= IDLE;
                            birdVisible <= 1'b0;
                            x_pos       <= SLING_X_FX;
                            y_pos       <= SLING_Y_FX;
                            vx          <= '0;
                            vy          <= '0;
                        end else begin
                            x_pos <= step_x;
                            y_pos <= step_y;
                            vy    <= step_vy;
                        end
                    end

                    HIT: begin
                        if (hold_cnt == '0) begin
                            state       <= IDLE;
                            birdVisible <= 1'b0;
                            x_pos       <= SLING_X_FX;
                            y_pos       <= SLING_Y_FX;
                            vx          <= '0;
                            vy          <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - HOLD_W'(1);
                        end
                    end

                    default: begin
                        state       <= IDLE;
                        birdVisible <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Integer pixel part of the registered fixed-point position.
    assign topLeftX = x_pos[16:6];
    assign topLeftY = y_pos[16:6];

endmodule

// File: tb/tb_bird_move.sv
module tb_bird_move;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               fireKey;
    logic               powerUpKey;
    logic               powerDownKey;
    logic               collision;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               birdVisible;
    logic [9:0]         power;

    int tests_run;
    int tests_failed;

    bird_move dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .fireKey      (fireKey),
        .powerUpKey   (powerUpKey),
        .powerDownKey (powerDownKey),
        .collision    (collision),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .birdVisible  (birdVisible),
        .power        (power)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic up;
        logic down;
        logic fire;
        int   x;
        int   y;
        int   vis;
        int   pw;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int x, input int y,
                             input int vis, input int pw);
        check({tag, " x"},   int'(topLeftX), x);
        check({tag, " y"},   int'(topLeftY), y);
        check({tag, " vis"}, int'(birdVisible), vis);
        check({tag, " pw"},  int'(power), pw);
    endtask

    task automatic keys(input logic up, input logic down, input logic fire);
        @(negedge clk);
        powerUpKey   = up;
        powerDownKey = down;
        fireKey      = fire;
        @(negedge clk);
        powerUpKey   = 1'b0;
        powerDownKey = 1'b0;
        fireKey      = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        fireKey      = 1'b0;
        powerUpKey   = 1'b0;
        powerDownKey = 1'b0;
        collision    = 1'b0;

        //               up    down  fire   x    y   vis  pw
        vecs[0]  = '{1'b0, 1'b0, 1'b0,  64, 352, 0,  64};
        vecs[1]  = '{1'b0, 1'b0, 1'b0,  64, 352, 0,  64};
        vecs[2]  = '{1'b0, 1'b0, 1'b0,  64, 352, 0,  64};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  64, 352, 0,  80};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  64, 352, 0,  96};
        vecs[5]  = '{1'b1, 1'b0, 1'b0,  64, 352, 0, 112};
        vecs[6]  = '{1'b1, 1'b1, 1'b0,  64, 352, 0, 112};
        vecs[7]  = '{1'b0, 1'b1, 1'b0,  64, 352, 0,  96};
        vecs[8]  = '{1'b0, 1'b1, 1'b0,  64, 352, 0,  80};
        vecs[9]  = '{1'b0, 1'b1, 1'b0,  64, 352, 0,  64};
        vecs[10] = '{1'b0, 1'b1, 1'b0,  64, 352, 0,  64};
        vecs[11] = '{1'b0, 1'b0, 1'b1,  65, 351, 1,  64};
        vecs[12] = '{1'b0, 1'b0, 1'b0,  66, 350, 1,  64};

        repeat (3) @(negedge clk);
        check_all("reset", 64, 352, 0, 64);
        resetN = 1'b1;

        // Power trim, saturation, cancel and launch: one frame per row.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].up || vecs[i].down || vecs[i].fire)
                keys(vecs[i].up, vecs[i].down, vecs[i].fire);
            frame();
            check_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                      vecs[i].vis, vecs[i].pw);
        end

        // Power 64 flight: step 74 sits just above the floor, step 75 would
        // cross it. Collision in the same cycle as that update wins.
        repeat (72) frame();
        check_all("pre_floor", 138, 446, 1, 64);
        @(negedge clk);
        startOfFrame = 1'b1;
        collision    = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        check_all("col_freeze", 138, 446, 1, 64);
        repeat (29) frame();
        check_all("hit_hold29", 138, 446, 1, 64);
        frame();
        check_all("hit_end", 64, 352, 0, 64);

        // Same flight without collision reaches the floor and clamps.
        keys(1'b0, 1'b0, 1'b1);
        repeat (74) frame();
        check_all("floor_pre", 138, 446, 1, 64);
        frame();
        check_all("floor_clamp", 139, 448, 1, 64);
`ifdef BIRD_BOUNCE_EN
        // vy 232 into the floor reflects to -116: y = 28672 - 116.
        frame();
        check_all("bounce_up", 140, 446, 1, 64);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_all("bounce_reset", 64, 352, 0, 64);
        @(negedge clk);
        resetN = 1'b1;
`else
        repeat (29) frame();
        check_all("floor_hold", 139, 448, 1, 64);
        frame();
        check_all("floor_end", 64, 352, 0, 64);
`endif

        // Saturate power high, then a full-power flight off the right edge.
        repeat (40) begin
            keys(1'b1, 1'b0, 1'b0);
            frame();
        end
        check("pw_max", int'(power), 512);
        keys(1'b0, 1'b0, 1'b1);
        frame();
        check_all("fast_launch", 72, 344, 1, 512);
        keys(1'b0, 1'b1, 1'b0);
        frame();
        check("pw_ignored_flying", int'(power), 512);
        repeat (69) frame();
        check_all("fast_k71", 632, -61, 1, 512);
        frame();
        check_all("exit_right", 64, 352, 0, 512);

        // Reset mid-flight with a pending power-up flag.
        keys(1'b0, 1'b0, 1'b1);
        repeat (5) frame();
        check("mid_vis", int'(birdVisible), 1);
        keys(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_all("async_reset", 64, 352, 0, 64);
        @(negedge clk);
        resetN = 1'b1;
        frame();
        check_all("flags_dropped", 64, 352, 0, 64);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
